// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one fp32 multiplier between requesters
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_op1,
  input  logic [32*N_REQ-1:0]  req_op2,
  output logic [31:0]          mul_op1,
  output logic [31:0]          mul_op2,
  input  logic [31:0]          mul_result,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mul_op1;
  logic [31:0]      r_mul_op2;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [31:0]      r_rsp_result;

  logic [ID_W-1:0]  w_grant_id;
  logic             w_grant_found;
  logic [N_REQ-1:0] w_grant_onehot;
  logic             w_accept;
  logic             w_done;
  logic             w_release;

  // Round-robin search: first valid requester after the last one granted, wrapping
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_grant_found && req_valid[(int'(r_last_grant) + k) % N_REQ]) begin
        w_grant_found = 1'b1;
        w_grant_id    = ID_W'((int'(r_last_grant) + k) % N_REQ);
      end
    end
  end

  // Grant is offered only while idle and out of reset
  always_comb begin
    w_grant_onehot = '0;
    if (rst_n && (r_state == S_IDLE) && w_grant_found) begin
      w_grant_onehot[w_grant_id] = 1'b1;
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_grant_found;
  assign w_done    = (r_state == S_WAIT) && (r_cnt == CNT_ONE);
  assign w_release = (r_state == S_RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done)    w_state_nxt = S_RESP;
      S_RESP:  if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on accept; operands stay put until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_op1    <= '0;
      r_mul_op2    <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
    end else if (w_accept) begin
      r_mul_op1    <= req_op1[32*w_grant_id +: 32];
      r_mul_op2    <= req_op2[32*w_grant_id +: 32];
      r_last_grant <= w_grant_id;
    end
  end

  // Latency counter: loaded on accept, result sampled when it reaches one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= LAT_INIT;
    end else if ((r_state == S_WAIT) && !w_done) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Response channel: id tagged at accept, result captured at end of wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_rsp_id <= w_grant_id;
      end
      if (w_done) begin
        r_rsp_result <= mul_result;
        r_rsp_valid  <= 1'b1;
      end else if (w_release) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign req_ready  = w_grant_onehot;
  assign mul_op1    = r_mul_op1;
  assign mul_op2    = r_mul_op2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - directed self-checking bench for fp_mul_arbiter
module tb_fp_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: MUL_LAT = 1, multiplier modelled by bench function
  logic         a_rst_n;
  logic [3:0]   a_req_valid;
  logic [3:0]   a_req_ready;
  logic [127:0] a_req_op1;
  logic [127:0] a_req_op2;
  logic [31:0]  a_mul_op1;
  logic [31:0]  a_mul_op2;
  logic [31:0]  a_mul_result;
  logic         a_rsp_valid;
  logic [1:0]   a_rsp_id;
  logic [31:0]  a_rsp_result;
  logic         a_rsp_ready;
  logic         a_busy;

  // DUT B: MUL_LAT = 3, multiplier output driven directly by bench
  logic         b_rst_n;
  logic [3:0]   b_req_valid;
  logic [3:0]   b_req_ready;
  logic [127:0] b_req_op1;
  logic [127:0] b_req_op2;
  logic [31:0]  b_mul_op1;
  logic [31:0]  b_mul_op2;
  logic [31:0]  b_mul_result;
  logic         b_rsp_valid;
  logic [1:0]   b_rsp_id;
  logic [31:0]  b_rsp_result;
  logic         b_rsp_ready;
  logic         b_busy;

  function automatic logic [31:0] mdl(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h4000_0000 && y == 32'h4040_0000) return 32'h40C0_0000;
    return x ^ y;
  endfunction

  assign a_mul_result = mdl(a_mul_op1, a_mul_op2);

  fp_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op1(a_req_op1), .req_op2(a_req_op2),
    .mul_op1(a_mul_op1), .mul_op2(a_mul_op2), .mul_result(a_mul_result),
    .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_result(a_rsp_result),
    .rsp_ready(a_rsp_ready), .busy(a_busy)
  );

  fp_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op1(b_req_op1), .req_op2(b_req_op2),
    .mul_op1(b_mul_op1), .mul_op2(b_mul_op2), .mul_result(b_mul_result),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_result(b_rsp_result),
    .rsp_ready(b_rsp_ready), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full operation on DUT A for requester g (bounded waits)
  task automatic run_op_a(input int g);
    int n;
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = a_req_op1[32*g +: 32];
    e2 = a_req_op2[32*g +: 32];
    n = 0;
    while (a_req_ready == 4'b0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant", 32'(a_req_ready), 32'(4'b0001 << g));
    @(negedge clk); #1;
    chk("busy_after_accept", 32'(a_busy), 32'd1);
    chk("mul_op1", a_mul_op1, e1);
    n = 0;
    while (!a_rsp_valid && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("rsp_id", 32'(a_rsp_id), 32'(g));
    chk("rsp_result", a_rsp_result, mdl(e1, e2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_res;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req_valid = 4'hF; b_req_valid = 4'h0;
    a_req_op1 = '0; a_req_op2 = '0; b_req_op1 = '0; b_req_op2 = '0;
    a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    b_mul_result = '0;
    #1;
    // Reset state
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_mul_op1", a_mul_op1, 32'd0);
    chk("rst_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("rst_rsp_result", a_rsp_result, 32'd0);

    // Test 1: single request, MUL_LAT=1
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_req_valid = 4'b0001;
    a_req_op1[31:0] = 32'h4000_0000;
    a_req_op2[31:0] = 32'h4040_0000;
    a_rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 32'(a_req_ready), 32'h1);
    @(negedge clk); #1;
    chk("t1_busy", 32'(a_busy), 32'd1);
    chk("t1_mul_op1", a_mul_op1, 32'h4000_0000);
    chk("t1_mul_op2", a_mul_op2, 32'h4040_0000);
    chk("t1_no_rsp_yet", 32'(a_rsp_valid), 32'd0);
    chk("t1_ready_wait", 32'(a_req_ready), 32'd0);
    a_req_valid = 4'b0000;
    @(negedge clk); #1;
    chk("t1_rsp_valid", 32'(a_rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("t1_rsp_result", a_rsp_result, 32'h40C0_0000);
    @(negedge clk); #1;
    chk("t1_rsp_drop", 32'(a_rsp_valid), 32'd0);
    chk("t1_idle", 32'(a_busy), 32'd0);
    chk("t1_op_hold", a_mul_op1, 32'h4000_0000);
    a_req_valid = 4'b0001;
    #1;
    chk("t1_ready_again", 32'(a_req_ready), 32'h1);
    a_req_valid = 4'b0000;

    // Test 2: round robin with all requesters valid
    @(negedge clk);
    a_rst_n = 1'b0;
    #1;
    @(negedge clk);
    a_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_req_op1[32*i +: 32] = 32'h3F80_0000 + (32'(i) << 20);
      a_req_op2[32*i +: 32] = 32'h4000_0000 + 32'(i) + 32'h10;
    end
    a_req_valid = 4'b1111;
    a_rsp_ready = 1'b1;
    #1;
    run_op_a(0);
    run_op_a(1);
    run_op_a(2);
    run_op_a(3);
    run_op_a(0);
    run_op_a(1);

    // Test 3: backpressure in RESP
    @(negedge clk); #1;
    a_rsp_ready = 1'b0;
    #1;
    run_op_a(2);
    hold_res = mdl(a_req_op1[95:64], a_req_op2[95:64]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("bp_valid", 32'(a_rsp_valid), 32'd1);
      chk("bp_id", 32'(a_rsp_id), 32'd2);
      chk("bp_result", a_rsp_result, hold_res);
      chk("bp_ready", 32'(a_req_ready), 32'd0);
      chk("bp_busy", 32'(a_busy), 32'd1);
    end
    a_rsp_ready = 1'b1;
    run_op_a(3);

    // Test 6: sparse wrap-around, only requesters 2 and 3
    @(negedge clk);
    a_rst_n = 1'b0;
    #1;
    @(negedge clk);
    a_rst_n = 1'b1;
    a_req_valid = 4'b1100;
    #1;
    run_op_a(2);
    run_op_a(3);
    run_op_a(2);
    a_req_valid = 4'b0000;

    // Test 4: MUL_LAT=3 with a moving multiplier output
    @(negedge clk);
    b_req_op1[31:0] = 32'h4049_0FDB;
    b_req_op2[31:0] = 32'h3EA2_F983;
    b_mul_result = 32'h1111_1111;
    b_req_valid = 4'b0001;
    b_rsp_ready = 1'b0;
    #1;
    chk("t4_ready", 32'(b_req_ready), 32'h1);
    @(negedge clk); #1;
    chk("t4_busy", 32'(b_busy), 32'd1);
    chk("t4_no_rsp_t0", 32'(b_rsp_valid), 32'd0);
    chk("t4_op1_t0", b_mul_op1, 32'h4049_0FDB);
    chk("t4_op2_t0", b_mul_op2, 32'h3EA2_F983);
    b_req_valid = 4'b0000;
    b_mul_result = 32'h2222_2222;
    @(negedge clk); #1;
    chk("t4_no_rsp_t1", 32'(b_rsp_valid), 32'd0);
    chk("t4_op1_t1", b_mul_op1, 32'h4049_0FDB);
    b_mul_result = 32'h3333_3333;
    @(negedge clk); #1;
    chk("t4_no_rsp_t2", 32'(b_rsp_valid), 32'd0);
    b_mul_result = 32'h3F80_0000;
    @(negedge clk); #1;
    chk("t4_rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("t4_rsp_result", b_rsp_result, 32'h3F80_0000);
    chk("t4_rsp_id", 32'(b_rsp_id), 32'd0);
    chk("t4_op1_t3", b_mul_op1, 32'h4049_0FDB);
    chk("t4_op2_t3", b_mul_op2, 32'h3EA2_F983);
    b_rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("t4_rsp_drop", 32'(b_rsp_valid), 32'd0);
    chk("t4_idle", 32'(b_busy), 32'd0);

    // Test 5: reset during WAIT discards the operation
    b_req_op1[95:64] = 32'h4120_0000;
    b_req_op2[95:64] = 32'h41A0_0000;
    b_req_valid = 4'b0100;
    #1;
    chk("t5_ready", 32'(b_req_ready), 32'h4);
    @(negedge clk); #1;
    chk("t5_busy", 32'(b_busy), 32'd1);
    b_rst_n = 1'b0;
    #1;
    chk("t5_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("t5_rst_busy", 32'(b_busy), 32'd0);
    chk("t5_rst_op1", b_mul_op1, 32'd0);
    chk("t5_rst_op2", b_mul_op2, 32'd0);
    chk("t5_rst_ready", 32'(b_req_ready), 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    b_req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("t5_no_rsp", 32'(b_rsp_valid), 32'd0);
      chk("t5_idle", 32'(b_busy), 32'd0);
    end
    b_req_valid = 4'b1001;
    #1;
    chk("t5_first_prio", 32'(b_req_ready), 32'h1);
    b_req_valid = 4'b0000;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one combinational IEEE 754 single-precision multiplier between N_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake on each request port and one response channel tagged with the requester ID.
- Sits between the compute clients and the multiplier instance.
- Drives the multiplier operand inputs from registers, waits a configurable number of cycles, then captures and returns the result.

Parameters:
- N_REQ, 4: number of requesters. Legal range 2..8.
- ID_W, 2: response ID width. Must equal clog2(N_REQ).
- MUL_LAT, 1: cycles from driving the operand registers to sampling mul_result. Must be >= 1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero
- req_op1  input  32*N_REQ  operand 1 per requester, slice i = [32*i+31:32*i]
- req_op2  input  32*N_REQ  operand 2 per requester, same slicing
- mul_op1  output  32  registered operand 1 to the multiplier
- mul_op2  output  32  registered operand 2 to the multiplier
- mul_result  input  32  product from the multiplier
- rsp_valid  output  1  response valid
- rsp_id  output  ID_W  index of the requester that owns the response
- rsp_result  output  32  captured product
- rsp_ready  input  1  response consumer accept
- busy  output  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; rsp_valid = 0; rsp_id = 0; rsp_result = 0; mul_op1 = mul_op2 = 0.
  - Round-robin pointer last_grant = N_REQ-1, so requester 0 has first priority.
  - req_ready = 0 while rst_n is low.
- Reset mid-operation: the in-flight operation is discarded with no response. All outputs return to reset values immediately (asynchronous).
- FSM states: IDLE, WAIT, RESP.
- IDLE arbitration:
  - Winner g = first i with req_valid[i] set, searching from last_grant+1 upward and wrapping at N_REQ-1 to 0.
  - req_ready is combinational: only bit g is set, and only in IDLE. req_ready = 0 in WAIT and RESP.
- IDLE accept (at edge T with req_valid[g] and req_ready[g]):
  - mul_op1/2 <= req_op1/2 slice g; rsp_id <= g; last_grant <= g; counter <= MUL_LAT; go to WAIT.
- WAIT:
  - mul_op1/2 are held stable.
  - The counter decrements each edge. At the edge where counter == 1: rsp_result <= mul_result, rsp_valid <= 1, go to RESP.
  - The result is therefore sampled at edge T+MUL_LAT, and rsp_valid is high from T+MUL_LAT.
- RESP:
  - rsp_valid, rsp_id and rsp_result are held stable until rsp_ready.
  - At an edge with rsp_valid and rsp_ready: rsp_valid <= 0, go to IDLE.
  - No request is accepted in that same cycle. Maximum throughput is one operation per MUL_LAT+2 cycles.
- mul_op1/2 keep their last values after completion. They change only on accept.
- Requesters may deassert req_valid before being granted. Arbitration is re-evaluated every IDLE cycle. The block does not check requester protocol.
- The block never inspects floating-point fields. Result bits, including zero and infinity encodings, pass through unchanged.
- An idle cycle with no req_valid leaves all state unchanged, including last_grant.

Test Plan:
1. Single request, MUL_LAT=1:
   - Stimulus: req_valid=4'b0001, op1=0x40000000, op2=0x40400000; model multiplier returns 0x40C00000.
   - Required: req_ready=4'b0001 in the same cycle; rsp_valid high one edge after accept with rsp_id=0, rsp_result=0x40C00000. With rsp_ready=1, rsp_valid falls the next edge and req_ready returns in IDLE.
2. Round robin:
   - Stimulus: req_valid=4'b1111 held continuously, rsp_ready=1.
   - Required: grant order 0,1,2,3,0,1, with rsp_id matching each grant.
3. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles in RESP while req_valid=4'b1111.
   - Required: rsp_valid/rsp_id/rsp_result stable, req_ready=0, busy=1. After rsp_ready=1, the next grant goes to the next requester in rotation.
4. MUL_LAT=3:
   - Stimulus: accept at edge T; mul_result changes at T+1 and T+2, then settles to 0x3F800000.
   - Required: rsp_valid low until edge T+3, then rsp_result=0x3F800000; mul_op1/2 stable throughout.
5. Reset mid-WAIT (MUL_LAT=3):
   - Stimulus: pull rst_n low one cycle after accept.
   - Required: rsp_valid=0, busy=0, mul_op1/2=0 immediately, and no response after release. With req_valid=4'b1001 after release, requester 0 is granted first.
6. Sparse wrap-around:
   - Stimulus: only requesters 2 and 3 valid, starting from last_grant=3.
   - Required: grants alternate 2,3,2. Requesters 0 and 1 are never granted and never see req_ready.
